// File: rtl/csa_ctrl_pkg.sv
// Shared types and default sizes for the carry-save accumulator controller.
package csa_ctrl_pkg;

  localparam int unsigned CSA_WIDTH_DEF = 32;
  localparam int unsigned CSA_CNT_W_DEF = 8;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ACCUM   = 2'd1,
    ST_RESOLVE = 2'd2,
    ST_DONE    = 2'd3
  } csa_state_e;

endpackage : csa_ctrl_pkg

// File: rtl/csa_row.sv
// One row of full adders: compresses three WIDTH-bit words into sum and majority words.
module csa_row
  import csa_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH = CSA_WIDTH_DEF
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic [WIDTH-1:0] c_i,
  output logic [WIDTH-1:0] s_o,
  output logic [WIDTH-1:0] c_o
);

  always_comb begin
    s_o = a_i ^ b_i ^ c_i;
    c_o = (a_i & b_i) | (a_i & c_i) | (b_i & c_i);
  end

endmodule : csa_row

// File: rtl/csa_accum_ctrl.sv
// Carry-save accumulator: sums n_ops operands via a 3:2 row, resolves with one final add.
// Optional sticky overflow output enabled by defining CSA_ACC_OVF_EN.
module csa_accum_ctrl
  import csa_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH = CSA_WIDTH_DEF,
  parameter int unsigned CNT_W = CSA_CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [CNT_W-1:0] n_ops,
  input  logic             op_valid,
  input  logic [WIDTH-1:0] op_data,
  output logic             op_ready,
  output logic             res_valid,
  output logic [WIDTH-1:0] res_data,
  input  logic             res_ready,
`ifdef CSA_ACC_OVF_EN
  output logic             res_ovf,
`endif
  output logic             busy
);

  csa_state_e       state_q, state_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic [WIDTH-1:0] carry_q, carry_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             op_ready_q, op_ready_d;
  logic             res_valid_q, res_valid_d;
  logic             busy_q, busy_d;
  logic [WIDTH-1:0] row_s, row_c;
  logic             xfer;

`ifdef CSA_ACC_OVF_EN
  logic             ovf_q, ovf_d;
  logic [WIDTH:0]   final_sum;
  assign final_sum = {1'b0, sum_q} + {1'b0, carry_q};
`else
  logic [WIDTH-1:0] final_sum;
  assign final_sum = sum_q + carry_q;
`endif

  csa_row #(.WIDTH(WIDTH)) u_row (
    .a_i (sum_q),
    .b_i (carry_q),
    .c_i (op_data),
    .s_o (row_s),
    .c_o (row_c)
  );

  assign xfer = op_valid && op_ready_q;

  // Next-state and output decode; outputs are registered from the next state.
  always_comb begin
    state_d = state_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    res_d   = res_q;
`ifdef CSA_ACC_OVF_EN
    ovf_d   = ovf_q;
`endif
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          sum_d   = '0;
          carry_d = '0;
          cnt_d   = n_ops;
`ifdef CSA_ACC_OVF_EN
          ovf_d   = 1'b0;
`endif
          state_d = (n_ops == '0) ? ST_RESOLVE : ST_ACCUM;
        end
      end
      ST_ACCUM: begin
        // cnt_q is never zero here, so the decrement cannot wrap.
        if (xfer) begin
          sum_d   = row_s;
          carry_d = WIDTH'(row_c << 1);
          cnt_d   = cnt_q - CNT_W'(1);
`ifdef CSA_ACC_OVF_EN
          ovf_d   = ovf_q | row_c[WIDTH-1];
`endif
          if (cnt_q == CNT_W'(1)) begin
            state_d = ST_RESOLVE;
          end
        end
      end
      ST_RESOLVE: begin
        res_d   = final_sum[WIDTH-1:0];
`ifdef CSA_ACC_OVF_EN
        ovf_d   = ovf_q | final_sum[WIDTH];
`endif
        state_d = ST_DONE;
      end
      ST_DONE: begin
        if (res_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    op_ready_d  = (state_d == ST_ACCUM);
    res_valid_d = (state_d == ST_DONE);
    busy_d      = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      sum_q       <= '0;
      carry_q     <= '0;
      cnt_q       <= '0;
      res_q       <= '0;
      op_ready_q  <= 1'b0;
      res_valid_q <= 1'b0;
      busy_q      <= 1'b0;
`ifdef CSA_ACC_OVF_EN
      ovf_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      sum_q       <= sum_d;
      carry_q     <= carry_d;
      cnt_q       <= cnt_d;
      res_q       <= res_d;
      op_ready_q  <= op_ready_d;
      res_valid_q <= res_valid_d;
      busy_q      <= busy_d;
`ifdef CSA_ACC_OVF_EN
      ovf_q       <= ovf_d;
`endif
    end
  end

  assign op_ready  = op_ready_q;
  assign res_valid = res_valid_q;
  assign res_data  = res_q;
  assign busy      = busy_q;
`ifdef CSA_ACC_OVF_EN
  assign res_ovf   = ovf_q;
`endif

endmodule : csa_accum_ctrl

// File: tb/tb_csa_accum_ctrl.sv
// Directed bench for csa_accum_ctrl: driver pushes expected results, a negedge monitor checks them.
module tb_csa_accum_ctrl;

  localparam int unsigned W  = 32;
  localparam int unsigned CW = 8;

  typedef struct {
    logic [W-1:0] data;
    logic         ovf;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic [CW-1:0] n_ops;
  logic          op_valid;
  logic [W-1:0]  op_data;
  logic          op_ready;
  logic          res_valid;
  logic [W-1:0]  res_data;
  logic          res_ready;
  logic          busy;
`ifdef CSA_ACC_OVF_EN
  logic          res_ovf;
`endif

  int   n_vec = 0;
  int   n_err = 0;
  int   n_res = 0;
  exp_t exp_q[$];

  logic         watch_rdy = 1'b0;
  logic         saw_rdy   = 1'b0;
  logic         stall_prev = 1'b0;
  logic [W-1:0] stall_data = '0;

  csa_accum_ctrl #(.WIDTH(W), .CNT_W(CW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .n_ops     (n_ops),
    .op_valid  (op_valid),
    .op_data   (op_data),
    .op_ready  (op_ready),
    .res_valid (res_valid),
    .res_data  (res_data),
    .res_ready (res_ready),
`ifdef CSA_ACC_OVF_EN
    .res_ovf   (res_ovf),
`endif
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: result handshakes, hold-stability while stalled, op_ready watch.
  always @(negedge clk) begin
    if (watch_rdy && op_ready) saw_rdy <= 1'b1;
    if (res_valid && stall_prev) chk("res_stable", 64'(res_data), 64'(stall_data));
    if (res_valid && res_ready) begin
      n_res++;
      if (exp_q.size() == 0) begin
        chk("unexpected_result", 64'(1), 64'(0));
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("res_data", 64'(res_data), 64'(e.data));
`ifdef CSA_ACC_OVF_EN
        chk("res_ovf", 64'(res_ovf), 64'(e.ovf));
`endif
      end
    end
    stall_prev <= res_valid && !res_ready;
    stall_data <= res_data;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle();
    int g = 0;
    while (busy && g < 100) begin tick(); g++; end
    if (busy) chk("idle_timeout", 64'(1), 64'(0));
  endtask

  task automatic start_job(input int n, input logic [W-1:0] d, input logic ovf);
    exp_t e;
    wait_idle();
    e.data = d;
    e.ovf  = ovf;
    exp_q.push_back(e);
    start = 1'b1;
    n_ops = CW'(n);
    tick();
    start = 1'b0;
  endtask

  task automatic send(input logic [W-1:0] d);
    int g = 0;
    op_valid = 1'b1;
    op_data  = d;
    while (!op_ready && g < 100) begin tick(); g++; end
    if (!op_ready) chk("op_ready_timeout", 64'(1), 64'(0));
    tick();
    op_valid = 1'b0;
  endtask

  // Edges from the transfer/start edge until res_valid; a two-cycle latency reads as 1.
  task automatic check_latency(input string name);
    int k = 0;
    while (!res_valid && k < 20) begin tick(); k++; end
    chk(name, 64'(k), 64'(1));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n     = 1'b0;
    start     = 1'b0;
    n_ops     = '0;
    op_valid  = 1'b0;
    op_data   = '0;
    res_ready = 1'b1;
    repeat (3) tick();
    chk("rst_op_ready", 64'(op_ready), 64'(0));
    chk("rst_res_valid", 64'(res_valid), 64'(0));
    chk("rst_res_data", 64'(res_data), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
`ifdef CSA_ACC_OVF_EN
    chk("rst_res_ovf", 64'(res_ovf), 64'(0));
`endif
    rst_n = 1'b1;
    tick();

    // 5 + 7 + 9 back-to-back
    start_job(3, 32'd21, 1'b0);
    chk("busy_in_job", 64'(busy), 64'(1));
    send(32'd5);
    send(32'd7);
    send(32'd9);
    check_latency("lat_3ops");

    // Empty job: straight to RESOLVE, op_ready must stay low
    wait_idle();
    watch_rdy = 1'b1;
    start_job(0, 32'd0, 1'b0);
    check_latency("lat_nops0");
    tick();
    watch_rdy = 1'b0;
    chk("nops0_op_ready_seen", 64'(saw_rdy), 64'(0));

    // Wrap past 2^32
    start_job(2, 32'h0000_0001, 1'b1);
    send(32'hFFFF_FFFF);
    send(32'h0000_0002);
    check_latency("lat_wrap");

    // Gapped operands, ignored start, stalled consumer
    start_job(4, 32'd10, 1'b0);
    send(32'd1);
    tick();
    send(32'd2);
    start = 1'b1;
    n_ops = CW'(7);
    tick();
    start = 1'b0;
    send(32'd3);
    tick();
    res_ready = 1'b0;
    send(32'd4);
    check_latency("lat_stall");
    repeat (5) tick();
    chk("stall_res_valid", 64'(res_valid), 64'(1));
    chk("stall_busy", 64'(busy), 64'(1));
    res_ready = 1'b1;
    tick();
    chk("after_hs_res_valid", 64'(res_valid), 64'(0));
    tick();
    chk("after_hs_busy", 64'(busy), 64'(0));

    // Reset mid-job aborts it
    start_job(4, 32'd10, 1'b0);
    send(32'd1);
    send(32'd2);
    rst_n = 1'b0;
    void'(exp_q.pop_back());
    #1;
    chk("midrst_op_ready", 64'(op_ready), 64'(0));
    chk("midrst_res_valid", 64'(res_valid), 64'(0));
    chk("midrst_res_data", 64'(res_data), 64'(0));
    chk("midrst_busy", 64'(busy), 64'(0));
`ifdef CSA_ACC_OVF_EN
    chk("midrst_res_ovf", 64'(res_ovf), 64'(0));
`endif
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    start_job(1, 32'd42, 1'b0);
    send(32'd42);
    check_latency("lat_after_rst");

    // Maximum count
    start_job(255, 32'hFF00_0000, 1'b0);
    for (int i = 0; i < 255; i++) send(32'h0100_0000);
    check_latency("lat_max");

    begin
      int g = 0;
      while (exp_q.size() != 0 && g < 100) begin tick(); g++; end
    end
    tick();
    chk("pending_expected", 64'(exp_q.size()), 64'(0));
    chk("results_seen", 64'(n_res), 64'(6));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule : tb_csa_accum_ctrl
